// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: two-level lookahead carries, sum, and group G/P.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               g,
  output logic               p
);

  logic [GROUP_W-1:0] gb, pb;
  logic [GROUP_W-1:0] c;

  assign gb = a & b;
  assign pb = a ^ b;

  assign c[0] = cin;
  assign c[1] = gb[0] | (pb[0] & cin);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) |
                (pb[2] & pb[1] & pb[0] & cin);

  assign s = pb ^ c;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) |
             (pb[3] & pb[2] & pb[1] & gb[0]);
  assign p = &pb;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/sub: each stage resolves GPS lookahead groups; operands are shifted
// down as they travel so every stage consumes the low bits of its operand registers.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned GPS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = int'(W / (GROUP_W * GPS));
  localparam int SW     = int'(GROUP_W * GPS);
  localparam int NG     = int'(W / GROUP_W);

  logic [STAGES-1:0]         valid_q, carry_q, sub_q;
  logic [STAGES-1:0][W-1:0]  a_q, b_q, sum_q;
  logic                      ovf_q;

  logic [STAGES-1:0]         v_in, c_in, s_in, co;
  logic [STAGES-1:0][W-1:0]  a_in, b_in, sum_in, sum_d;
  logic [STAGES-1:0][SW-1:0] beff;
  logic [NG-1:0]             g, p, gc;
  logic [W-1:0]              grp_sum;
  logic                      ovf_d;
  logic                      en;
  logic                      unused_last;

  assign out_valid = valid_q[STAGES-1];
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  assign v_in[0]   = in_valid;
  assign c_in[0]   = (sub == SUB) ? 1'b1 : cin;
  assign s_in[0]   = sub;
  assign a_in[0]   = a;
  assign b_in[0]   = b;
  assign sum_in[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign v_in[k]   = valid_q[k-1];
    assign c_in[k]   = carry_q[k-1];
    assign s_in[k]   = sub_q[k-1];
    assign a_in[k]   = a_q[k-1];
    assign b_in[k]   = b_q[k-1];
    assign sum_in[k] = sum_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_beff
    assign beff[k] = b_in[k][SW-1:0] ^ {SW{s_in[k]}};
  end

  for (genvar n = 0; n < NG; n++) begin : g_grp
    cla_group4 u_grp (
      .a   (a_in[n/GPS][(n%GPS)*GROUP_W +: GROUP_W]),
      .b   (beff[n/GPS][(n%GPS)*GROUP_W +: GROUP_W]),
      .cin (gc[n]),
      .s   (grp_sum[n*GROUP_W +: GROUP_W]),
      .g   (g[n]),
      .p   (p[n])
    );
  end

  // Sum-of-products lookahead per stage; index j == GPS yields the stage carry-out.
  always_comb begin
    logic cy, t;
    cy = 1'b0;
    t  = 1'b0;
    gc = '0;
    co = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j <= GPS; j++) begin
        cy = c_in[k];
        for (int i = 0; i < j; i++) cy = cy & p[k*GPS+i];
        for (int i = 0; i < j; i++) begin
          t = g[k*GPS+i];
          for (int m = i + 1; m < j; m++) t = t & p[k*GPS+m];
          cy = cy | t;
        end
        if (j < GPS) gc[k*GPS+j] = cy;
        else         co[k]       = cy;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]              = sum_in[k];
      sum_d[k][k*SW +: SW]  = grp_sum[k*SW +: SW];
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign ovf_d = co[STAGES-1] ^
                 (grp_sum[W-1] ^ a_in[STAGES-1][SW-1] ^ beff[STAGES-1][SW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= v_in;
      carry_q <= co;
      sub_q   <= s_in;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k] >> SW;
        b_q[k] <= b_in[k] >> SW;
      end
    end
  end

  // The last stage's operand copies have no consumer.
  assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], sub_q[STAGES-1]};

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and randomized checks of cla_pipe_addsub at W=16/GPS=1 and W=32/GPS=2.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32;
  logic [31:0] a32, b32, s32;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  cla_pipe_addsub #(.W(16), .GPS(1)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .sub       (sub16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (s16),
    .cout      (co16),
    .ovf       (of16)
  );

  cla_pipe_addsub #(.W(32), .GPS(2)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .a         (a32),
    .b         (b32),
    .cin       (cin32),
    .sub       (sub32),
    .out_valid (ov32),
    .out_ready (or32),
    .sum       (s32),
    .cout      (co32),
    .ovf       (of32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {cout, ovf, sum}; ovf from the operand/result sign rule.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb, input bit wide);
    logic [32:0] r;
    logic [31:0] bb;
    logic        c, ov;
    bb = sb ? ~b : b;
    c  = sb ? 1'b1 : ci;
    if (wide) begin
      r  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
      ov = (a[31] == bb[31]) && (r[31] != a[31]);
      return {r[32], ov, r[31:0]};
    end
    r  = {17'd0, a[15:0]} + {17'd0, bb[15:0]} + {32'd0, c};
    ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return {r[16], ov, 16'd0, r[15:0]};
  endfunction

  task automatic single16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb, input logic [15:0] es,
                          input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a16 = a; b16 = b; cin16 = ci; sub16 = sb; iv16 = 1'b1; or16 = 1'b1;
    #1 check({tag, "/in_ready"}, ir16, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv16 = 1'b0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "/latency"}, lat, 4);
    check({tag, "/sum"}, s16, es);
    check({tag, "/cout"}, co16, ec);
    check({tag, "/ovf"}, of16, eo);
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic [33:0] q [$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [33:0] e;
    logic [17:0] held;
    bit          held_v;
    int          sent, rcvd, stall_cnt, stray;
    rst = 1'b1;
    {iv16, or16, cin16, sub16, a16, b16} = '0;
    {iv32, or32, cin32, sub32, a32, b32} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset/out_valid", ov16, 0);
    check("reset/in_ready", ir16, 1);
    check("reset/outs", {co16, of16, s16}, 0);
    check("reset/out_valid32", ov32, 0);

    single16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    single16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single16("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single16("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    single16("add_grp",   16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Burst of 8 with a 3-cycle consumer stall once the pipe is full.
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'h1111 * 16'(i + 1);
      vb[i] = 16'hF00F - 16'(i * 3);
    end
    sent = 0; rcvd = 0; stall_cnt = 0; held_v = 0; held = '0;
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      @(negedge clk);
      or16 = !(c >= 5 && c <= 7);
      #1;
      if (!ir16) stall_cnt++;
      if (ov16 && !or16) begin
        if (held_v) check("burst/stable", {co16, of16, s16}, held);
        held   = {co16, of16, s16};
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (ov16 && or16) begin
        if (q.size() == 0) begin
          check("burst/extra", 1, 0);
        end else begin
          e = q.pop_front();
          check("burst/result", {co16, of16, s16}, {e[33:32], e[15:0]});
        end
        rcvd++;
      end
      if (sent < 8) begin
        iv16 = 1'b1; a16 = va[sent]; b16 = vb[sent];
        sub16 = sent[0]; cin16 = sent[1];
        if (ir16) begin
          q.push_back(model({16'd0, va[sent]}, {16'd0, vb[sent]}, sent[1], sent[0], 0));
          sent++;
        end
      end else begin
        iv16 = 1'b0;
      end
    end
    check("burst/stall_cycles", stall_cnt, 3);
    check("burst/received", rcvd, 8);
    check("burst/leftover", q.size(), 0);
    iv16 = 1'b0; or16 = 1'b1; stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) stray++;
    end
    check("burst/no_dup", stray, 0);

    // Reset with three transactions in flight; in_valid held high across it.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv16 = 1'b1; a16 = 16'h0100 * 16'(i + 1); b16 = 16'h0001; sub16 = 1'b0; cin16 = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; iv16 = 1'b0;
    #1;
    check("rst/out_valid", ov16, 0);
    check("rst/sum", s16, 0);
    check("rst/cout_ovf", {co16, of16}, 0);
    check("rst/in_ready", ir16, 1);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov16) stray++;
    end
    check("rst/no_emerge", stray, 0);

    // Randomized W=32/GPS=2 against the model with random backpressure.
    q.delete();
    sent = 0; rcvd = 0;
    for (int c = 0; c < 60000 && rcvd < 10000; c++) begin
      @(negedge clk);
      or32 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov32 && or32) begin
        if (q.size() == 0) begin
          check("rnd/extra", 1, 0);
        end else begin
          e = q.pop_front();
          check("rnd/result", {co32, of32, s32}, e);
        end
        rcvd++;
      end
      if (sent < 10000 && $urandom_range(0, 3) != 0) begin
        iv32 = 1'b1; a32 = $urandom; b32 = $urandom;
        cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
        if (ir32) begin
          q.push_back(model(a32, b32, cin32, sub32, 1));
          sent++;
        end
      end else begin
        iv32 = 1'b0;
      end
    end
    check("rnd/received", rcvd, 10000);
    check("rnd/leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
